ball_motion_sched: RTL and testbench
====================================

// Module: ball_motion_sched
//
// PURPOSE
//   Frame-rate motion scheduler for a bank of NUM_BALLS bouncing balls. Once per frame
//   (vsync rising edge), it walks every ball through one shared add/clamp datapath:
//   X first, then Y. All logic is synchronous to clk; edge-clocked collision flops are
//   not allowed. The renderer reads back positions combinationally through rd_idx.
//
// PARAMETERS
//   NUM_BALLS  4    number of balls (>=1); IW = max(1,$clog2(NUM_BALLS))
//   BALL_SIZE  20   ball edge length in pixels
//   H_MAX      256  visible width; X limit XL = H_MAX-BALL_SIZE
//   V_MAX      240  visible height; Y limit YL = V_MAX-BALL_SIZE
//   INIT_POS   128  reset X/Y base position
//   SPEED      2    reset velocity magnitude (1..BALL_SIZE)
//
// PORTS
//   clk         in   1   system clock
//   reset       in   1   reset, asynchronous, active-high
//   vsync       in   1   raw vsync from sync generator (async to clk)
//   pause       in   1   sampled at frame start; 1 = skip position updates this frame
//   rd_idx      in   IW  renderer read index
//   rd_hpos     out  9   X of ball rd_idx (combinational read)
//   rd_vpos     out  9   Y of ball rd_idx (combinational read)
//   busy        out  1   update sweep in progress
//   frame_done  out  1   1-cycle pulse at end of every accepted frame
//   bounce      out  1   1-cycle pulse when a clamp/reflect occurs
//   bounce_idx  out  IW  ball index qualified by bounce
//   bounce_axis out  1   0 = X, 1 = Y; qualified by bounce
//   overrun     out  1   1-cycle pulse: vsync edge arrived while busy, edge dropped
//
// BEHAVIOUR
//   - Reset (async): FSM=IDLE, idx=0, all pulse outputs and busy = 0. Ball i:
//     hpos=INIT_POS+8*i, vpos=INIT_POS; hvel=-SPEED for even i, +SPEED for odd i;
//     vvel=+SPEED. Reset mid-sweep aborts the sweep immediately; no partial state is kept.
//   - vsync: 2-flop synchroniser, then rising-edge detect on the synchronised value
//     (vs_rise, 1 cycle). vs_rise reaches the FSM 3 clk cycles after the raw edge.
//   - FSM states: IDLE, STEP_X, STEP_Y, DONE.
//       IDLE:   on vs_rise: idx<=0, latch pause into skip, go to STEP_X.
//       STEP_X: update X of ball idx, go to STEP_Y.
//       STEP_Y: update Y of ball idx. If idx==NUM_BALLS-1 go to DONE; else idx++ and
//               go to STEP_X.
//       DONE:   frame_done=1 for this cycle, then go to IDLE.
//   - busy=1 in STEP_X, STEP_Y and DONE. A sweep lasts exactly 2*NUM_BALLS+1 cycles.
//   - vs_rise in any state other than IDLE: overrun=1 that cycle; the edge is discarded.
//   - Step arithmetic (per axis): n = {1'b0,pos} + sign-extended vel, 10-bit signed.
//       n < 0      -> pos<=0,   vel<=-vel, bounce pulse
//       n > LIMIT  -> pos<=LIMIT, vel<=-vel, bounce pulse
//       otherwise  -> pos<=n[8:0], vel unchanged; n==LIMIT or n==0 is NOT a bounce
//   - skip=1: positions and velocities are held, bounce is never pulsed, and the FSM
//     still walks every state, so frame_done timing is unchanged.
//   - bounce, bounce_idx and bounce_axis are registered and assert in the cycle after
//     the step that clamped. Each step yields at most one pulse.
//   - Read port: out-of-range rd_idx returns 0. A position written in cycle t is
//     visible on the read port at t+1.
//
// TESTING
//   1. Reset, one vsync edge -> busy high 9 cycles (N=4). frame_done pulses in the last
//      busy cycle. Ball0=(126,130), ball1=(138,130).
//   2. 46 frames -> ball0 vpos=220, no Y bounce. Frame 47 -> vpos=220, vvel=-2,
//      bounce with idx=0, axis=1.
//   3. 64 frames -> ball0 hpos=0, no bounce. Frame 65 -> hpos=0, hvel=+2, bounce with
//      axis=0. Ball1 X clamps to 236 at frame 51.
//   4. Second vsync edge 4 cycles after the first -> overrun pulse. Only one update is
//      applied (ball0 hpos=126).
//   5. pause=1 at the edge -> frame_done still pulses. All positions unchanged. No bounce.
//   6. Assert reset in STEP_Y of idx=2 -> busy=0 immediately. All balls back at their
//      reset values. The next vsync runs a full, clean sweep.

Source files
------------

// File: rtl/ball_motion_sched.sv
// Frame-rate motion scheduler: on each synchronised vsync rising edge, sweeps every ball
// through one shared add/clamp datapath (X then Y) and exposes positions via a read port.
module ball_motion_sched #(
   parameter int unsigned NUM_BALLS = 4,
   parameter int unsigned BALL_SIZE = 20,
   parameter int unsigned H_MAX     = 256,
   parameter int unsigned V_MAX     = 240,
   parameter int unsigned INIT_POS  = 128,
   parameter int unsigned SPEED     = 2,
   parameter int unsigned IW        = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vsync,
   input  logic          pause,
   input  logic [IW-1:0] rd_idx,
   output logic [8:0]    rd_hpos,
   output logic [8:0]    rd_vpos,
   output logic          busy,
   output logic          frame_done,
   output logic          bounce,
   output logic [IW-1:0] bounce_idx,
   output logic          bounce_axis,
   output logic          overrun
);

   localparam int unsigned XL = H_MAX - BALL_SIZE;
   localparam int unsigned YL = V_MAX - BALL_SIZE;
   localparam logic signed [9:0] VEL0 = 10'(SPEED);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STEP_X = 2'd1,
      S_STEP_Y = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic          r_vs_meta;
   logic          r_vs_sync;
   logic          r_vs_prev;
   logic          w_vs_rise;

   logic [IW-1:0] r_idx;
   logic          r_skip;
   logic          w_last;

   logic [8:0]        r_hpos [NUM_BALLS];
   logic [8:0]        r_vpos [NUM_BALLS];
   logic signed [9:0] r_hvel [NUM_BALLS];
   logic signed [9:0] r_vvel [NUM_BALLS];

   logic              w_is_y;
   logic              w_stepping;
   logic [8:0]        w_pos;
   logic signed [9:0] w_vel;
   logic signed [9:0] w_limit;
   logic signed [9:0] w_sum;
   logic              w_under;
   logic              w_over;
   logic [8:0]        w_pos_nxt;
   logic signed [9:0] w_vel_nxt;

   logic          r_bounce;
   logic [IW-1:0] r_bounce_idx;
   logic          r_bounce_axis;

   // vsync is asynchronous: two-flop synchroniser followed by an edge detector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vs_meta <= 1'b0;
         r_vs_sync <= 1'b0;
         r_vs_prev <= 1'b0;
      end else begin
         r_vs_meta <= vsync;
         r_vs_sync <= r_vs_meta;
         r_vs_prev <= r_vs_sync;
      end
   end

   assign w_vs_rise = r_vs_sync & ~r_vs_prev;
   assign w_last    = (r_idx == IW'(NUM_BALLS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_vs_rise) w_state_nxt = S_STEP_X;
         S_STEP_X: w_state_nxt = S_STEP_Y;
         S_STEP_Y: w_state_nxt = w_last ? S_DONE : S_STEP_X;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Shared add/clamp datapath; the axis is selected by the current step state
   assign w_is_y     = (r_state == S_STEP_Y);
   assign w_stepping = ((r_state == S_STEP_X) || (r_state == S_STEP_Y)) && !r_skip;
   assign w_pos      = w_is_y ? r_vpos[r_idx] : r_hpos[r_idx];
   assign w_vel      = w_is_y ? r_vvel[r_idx] : r_hvel[r_idx];
   assign w_limit    = w_is_y ? 10'(YL) : 10'(XL);
   assign w_sum      = $signed({1'b0, w_pos}) + w_vel;
   assign w_under    = (w_sum < 10'sd0);
   assign w_over     = !w_under && (w_sum > w_limit);
   assign w_pos_nxt  = w_under ? 9'd0 : (w_over ? w_limit[8:0] : w_sum[8:0]);
   assign w_vel_nxt  = (w_under || w_over) ? -w_vel : w_vel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx  <= '0;
         r_skip <= 1'b0;
         for (int i = 0; i < int'(NUM_BALLS); i++) begin
            r_hpos[i] <= 9'(INIT_POS + 8 * i);
            r_vpos[i] <= 9'(INIT_POS);
            r_hvel[i] <= ((i % 2) == 0) ? -VEL0 : VEL0;
            r_vvel[i] <= VEL0;
         end
      end else begin
         if (r_state == S_IDLE && w_vs_rise) begin
            r_idx  <= '0;
            r_skip <= pause;
         end else if (r_state == S_STEP_Y && !w_last) begin
            r_idx <= r_idx + IW'(1);
         end
         if (w_stepping && !w_is_y) begin
            r_hpos[r_idx] <= w_pos_nxt;
            r_hvel[r_idx] <= w_vel_nxt;
         end
         if (w_stepping && w_is_y) begin
            r_vpos[r_idx] <= w_pos_nxt;
            r_vvel[r_idx] <= w_vel_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bounce      <= 1'b0;
         r_bounce_idx  <= '0;
         r_bounce_axis <= 1'b0;
      end else begin
         r_bounce <= w_stepping && (w_under || w_over);
         if (w_stepping && (w_under || w_over)) begin
            r_bounce_idx  <= r_idx;
            r_bounce_axis <= w_is_y;
         end
      end
   end

   assign bounce      = r_bounce;
   assign bounce_idx  = r_bounce_idx;
   assign bounce_axis = r_bounce_axis;
   assign busy        = (r_state != S_IDLE);
   assign frame_done  = (r_state == S_DONE);
   assign overrun     = w_vs_rise && (r_state != S_IDLE);

   assign rd_hpos = (32'(rd_idx) < NUM_BALLS) ? r_hpos[rd_idx] : 9'd0;
   assign rd_vpos = (32'(rd_idx) < NUM_BALLS) ? r_vpos[rd_idx] : 9'd0;

endmodule

// File: tb/tb_ball_motion_sched.sv
// Bench for ball_motion_sched: constant table of frame scenarios, hand-written corner
// sequences, and randomized frames checked against a plain-arithmetic ball model.
module tb_ball_motion_sched;

   localparam int N  = 4;
   localparam int XL = 236;
   localparam int YL = 220;

   logic       clk = 1'b0;
   logic       reset;
   logic       vsync;
   logic       pause;
   logic [1:0] rd_idx;
   logic [8:0] rd_hpos;
   logic [8:0] rd_vpos;
   logic       busy;
   logic       frame_done;
   logic       bounce;
   logic [1:0] bounce_idx;
   logic       bounce_axis;
   logic       overrun;

   ball_motion_sched dut (
      .clk(clk), .reset(reset), .vsync(vsync), .pause(pause), .rd_idx(rd_idx),
      .rd_hpos(rd_hpos), .rd_vpos(rd_vpos), .busy(busy), .frame_done(frame_done),
      .bounce(bounce), .bounce_idx(bounce_idx), .bounce_axis(bounce_axis),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int bq[$];
   int mq[$];
   int ov_cnt;
   int fd_cnt;
   int m_h[N], m_v[N], m_hv[N], m_vv[N];

   typedef struct {
      bit pause;
      int frames;
      int ball;
      int exp_h;
      int exp_v;
      int exp_b0;   // -2 don't care, -1 no bounce in last frame, else idx*2+axis of first
   } vec_t;
   vec_t tbl[10];

   always @(negedge clk) begin
      if (!reset) begin
         if (bounce)     bq.push_back(int'(bounce_idx) * 2 + int'(bounce_axis));
         if (overrun)    ov_cnt++;
         if (frame_done) fd_cnt++;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_ball(input string nm, input int i, input int eh, input int ev);
      rd_idx = 2'(i);
      #1;
      chk($sformatf("%s_b%0d_h", nm, i), int'(rd_hpos), eh);
      chk($sformatf("%s_b%0d_v", nm, i), int'(rd_vpos), ev);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_h[i]  = 128 + 8 * i;
         m_v[i]  = 128;
         m_hv[i] = (i % 2 == 1) ? 2 : -2;
         m_vv[i] = 2;
      end
   endtask

   task automatic model_axis(inout int p, inout int v, input int lim, output bit b);
      int n;
      n = p + v;
      b = 1'b0;
      if (n < 0) begin
         p = 0; v = -v; b = 1'b1;
      end else if (n > lim) begin
         p = lim; v = -v; b = 1'b1;
      end else begin
         p = n;
      end
   endtask

   task automatic model_frame(input bit p);
      bit b;
      mq.delete();
      if (!p) begin
         for (int i = 0; i < N; i++) begin
            model_axis(m_h[i], m_hv[i], XL, b);
            if (b) mq.push_back(i * 2);
            model_axis(m_v[i], m_vv[i], YL, b);
            if (b) mq.push_back(i * 2 + 1);
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1; vsync = 1'b0; pause = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One raw vsync edge; optionally a second edge while the sweep is still running
   task automatic run_frame(input bit p, input bit inj, output int bcnt, output int fd_at);
      ov_cnt = 0; fd_cnt = 0; bq.delete();
      bcnt = 0; fd_at = -1;
      @(negedge clk);
      pause = p; vsync = 1'b1;
      for (int k = 0; k < 8 && !busy; k++) @(negedge clk);
      while (busy && bcnt < 40) begin
         bcnt++;
         if (frame_done) fd_at = bcnt;
         if (inj && bcnt == 1) vsync = 1'b0;
         if (inj && bcnt == 3) vsync = 1'b1;
         @(negedge clk);
      end
      vsync = 1'b0; pause = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_frame(input bit p, input bit inj, input string tag);
      int bc, fa, nmin;
      run_frame(p, inj, bc, fa);
      model_frame(p);
      chk({tag, "_busy_len"}, bc, 2 * N + 1);
      chk({tag, "_done_at"}, fa, 2 * N + 1);
      chk({tag, "_done_cnt"}, fd_cnt, 1);
      chk({tag, "_overrun"}, ov_cnt, int'(inj));
      chk({tag, "_nbounce"}, bq.size(), mq.size());
      nmin = (bq.size() < mq.size()) ? bq.size() : mq.size();
      for (int k = 0; k < nmin; k++) chk($sformatf("%s_bounce%0d", tag, k), bq[k], mq[k]);
      for (int i = 0; i < N; i++) chk_ball(tag, i, m_h[i], m_v[i]);
   endtask

   initial begin
      int bc;
      tbl[0] = '{1'b0, 1,  0, 126, 130, -2};
      tbl[1] = '{1'b0, 0,  1, 138, 130, -2};
      tbl[2] = '{1'b0, 45, 0, 36,  220, -1};
      tbl[3] = '{1'b0, 1,  0, 34,  220,  1};
      tbl[4] = '{1'b0, 1,  0, 32,  218, -2};
      tbl[5] = '{1'b1, 3,  0, 32,  218, -1};
      tbl[6] = '{1'b0, 3,  1, 236, 212,  2};
      tbl[7] = '{1'b0, 13, 0, 0,   186, -1};
      tbl[8] = '{1'b0, 1,  0, 0,   184,  0};
      tbl[9] = '{1'b0, 1,  2, 12,  182, -2};

      reset = 1'b1; vsync = 1'b0; pause = 1'b0; rd_idx = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_bounce", int'(bounce), 0);
      chk("rst_overrun", int'(overrun), 0);
      model_reset();
      for (int i = 0; i < N; i++) chk_ball("rst", i, m_h[i], m_v[i]);
      reset = 1'b0;

      // Cumulative frame table starting from reset
      for (int r = 0; r < 10; r++) begin
         for (int f = 0; f < tbl[r].frames; f++) do_frame(tbl[r].pause, 1'b0, $sformatf("tbl%0d", r));
         chk_ball($sformatf("tbl%0d_exp", r), tbl[r].ball, tbl[r].exp_h, tbl[r].exp_v);
         if (tbl[r].exp_b0 == -1) chk($sformatf("tbl%0d_nobounce", r), bq.size(), 0);
         else if (tbl[r].exp_b0 >= 0)
            chk($sformatf("tbl%0d_first_bounce", r), (bq.size() > 0) ? bq[0] : -1, tbl[r].exp_b0);
      end

      // Second raw edge 4 cycles after the first is dropped with an overrun pulse
      apply_reset();
      ov_cnt = 0; fd_cnt = 0; bq.delete();
      @(negedge clk); vsync = 1'b1;
      repeat (2) @(negedge clk); vsync = 1'b0;
      repeat (2) @(negedge clk); vsync = 1'b1;
      bc = 0;
      while (busy && bc < 40) begin bc++; @(negedge clk); end
      chk("ovr_still_busy_after_edge2", int'(bc > 0), 1);
      vsync = 1'b0;
      repeat (15) @(negedge clk);
      chk("ovr_overrun_cnt", ov_cnt, 1);
      chk("ovr_done_cnt", fd_cnt, 1);
      model_frame(1'b0);
      chk_ball("ovr", 0, 126, 130);
      for (int i = 1; i < N; i++) chk_ball("ovr", i, m_h[i], m_v[i]);

      // Paused frame: sweep timing unchanged, nothing moves
      do_frame(1'b1, 1'b0, "pause");
      chk("pause_nobounce", bq.size(), 0);
      chk_ball("pause_b0", 0, 126, 130);

      // Reset during STEP_Y of ball 2 aborts the sweep
      apply_reset();
      do_frame(1'b0, 1'b0, "pre_abort");
      @(negedge clk); vsync = 1'b1;
      for (int k = 0; k < 8 && !busy; k++) @(negedge clk);
      bc = 0;
      while (busy && bc < 5) begin bc++; @(negedge clk); end
      chk("abort_in_step_y2", int'(busy), 1);
      reset = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      model_reset();
      for (int i = 0; i < N; i++) chk_ball("abort", i, m_h[i], m_v[i]);
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      do_frame(1'b0, 1'b0, "post_abort");
      chk_ball("post_abort_b3", 3, 154, 130);

      // Randomized frames against the model
      apply_reset();
      for (int f = 0; f < 40; f++)
         do_frame(($urandom % 5) == 0, ($urandom % 4) == 0, $sformatf("rnd%0d", f));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
